// File: rtl/data_mem_responder.sv
// Word-organised data-memory responder: programmable wait states, CPU stall, one-cycle ack and error reporting.
// Optional byte-lane write strobes are enabled by defining MEM_BYTE_EN_EN.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef MEM_BYTE_EN_EN
  input  logic [3:0]  req_wstrb,
`endif
  output logic [31:0] resp_rdata,
  output logic        resp_ack,
  output logic        resp_err,
  output logic        stall,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifndef SYNTHESIS
  if (WAIT_CYCLES > 15) begin : g_wait_range_check
    $error("data_mem_responder: WAIT_CYCLES must be in 0..15");
  end
`endif

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              wait_cnt;
  logic [3:0]              wait_cnt_nxt;
  logic                    enter_resp;

  logic [31:0]             mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    write_q;
  logic [3:0]              wstrb_q;

  logic                    req;
  logic                    req_bad;
  logic [3:0]              req_strb;

  logic                    in_idle;
  logic                    op_write;
  logic [ADDR_WIDTH-1:0]   op_idx;
  logic [31:0]             op_wdata;
  logic [3:0]              op_wstrb;
  logic                    mem_we;

`ifdef MEM_BYTE_EN_EN
  assign req_strb = req_wstrb;
`else
  assign req_strb = 4'hF;
`endif

  assign req     = req_ren | req_wen;
  assign req_bad = (req_addr[1:0] != 2'b00)
                 || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0)
                 || (req_ren && req_wen);

  // With zero wait states the RAM access happens on the acceptance edge,
  // before the capture registers hold the request, so use the live inputs in IDLE.
  assign in_idle  = (state == IDLE);
  assign op_write = in_idle ? req_wen                       : write_q;
  assign op_idx   = in_idle ? req_addr[ADDR_WIDTH+1:2]      : addr_q;
  assign op_wdata = in_idle ? req_wdata                     : wdata_q;
  assign op_wstrb = in_idle ? req_strb                      : wstrb_q;

  assign mem_we = rst_n & enter_resp & op_write;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    enter_resp   = 1'b0;
    stall        = 1'b0;
    resp_ack     = 1'b0;
    resp_err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (req_bad) begin
            state_nxt = ERR;
          end else if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (wait_cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        resp_ack  = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        resp_ack  = 1'b1;
        resp_err  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and the registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      resp_rdata <= 32'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (enter_resp && !op_write) begin
        resp_rdata <= mem[op_idx];
      end
    end
  end

  // Request capture: only sampled while idle, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (in_idle && req) begin
      addr_q  <= req_addr[ADDR_WIDTH+1:2];
      wdata_q <= req_wdata;
      write_q <= req_wen;
      wstrb_q <= req_strb;
    end
  end

  // RAM write with per-byte-lane enables.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (op_wstrb[i]) begin
          mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table vectors, hand-written corner sequences and a randomized model check.
module tb_data_mem_responder;

  localparam int AW    = 8;
  localparam int WAIT  = 2;
  localparam int DEPTH = 2 ** AW;
`ifdef MEM_BYTE_EN_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_ren, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] resp_rdata;
  logic        resp_ack, resp_err, stall, busy;

  logic        w0_ren, w0_wen;
  logic [31:0] w0_addr, w0_wdata;
  logic [31:0] w0_rdata;
  logic        w0_ack, w0_err, w0_stall, w0_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_BYTE_EN_EN
    .req_wstrb(req_wstrb),
`endif
    .resp_rdata(resp_rdata), .resp_ack(resp_ack), .resp_err(resp_err),
    .stall(stall), .busy(busy)
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n), .req_ren(w0_ren), .req_wen(w0_wen),
    .req_addr(w0_addr), .req_wdata(w0_wdata),
`ifdef MEM_BYTE_EN_EN
    .req_wstrb(4'hF),
`endif
    .resp_rdata(w0_rdata), .resp_ack(w0_ack), .resp_err(w0_err),
    .stall(w0_stall), .busy(w0_busy)
  );

  typedef struct {
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: error rule and RAM effect computed from plain address arithmetic.
  function automatic void model_apply(input bit ren, input bit wen, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] strb,
                                      output bit e, output logic [31:0] rd);
    logic [3:0] eff;
    int         w;
    eff = BYTE_EN ? strb : 4'hF;
    e   = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH)) || (ren && wen);
    rd  = model_rdata;
    if (!e) begin
      w = int'(addr / 4);
      if (wen) begin
        for (int i = 0; i < 4; i++)
          if (eff[i]) model_mem[w][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        rd = model_mem[w];
      end
    end
  endfunction

  // One request held until its ack, checked cycle by cycle, then one idle cycle.
  task automatic xact(input bit ren, input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input bit exp_err, input logic [31:0] exp_rdata,
                      input string tag);
    int lat;
    lat = exp_err ? 1 : WAIT + 1;
    @(posedge clk); #1;
    req_ren = ren; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      chk({tag, "_stall"}, {31'd0, stall}, {31'd0, k < lat});
      chk({tag, "_ack"},   {31'd0, resp_ack}, {31'd0, k == lat});
      chk({tag, "_err"},   {31'd0, resp_err}, {31'd0, (k == lat) && exp_err});
      chk({tag, "_busy"},  {31'd0, busy}, {31'd0, k > 0});
      chk({tag, "_rdata"}, resp_rdata, (k == lat) ? exp_rdata : model_rdata);
    end
    model_rdata = exp_rdata;
    @(posedge clk); #1;
    req_ren = 1'b0; req_wen = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    @(negedge clk);
    chk({tag, "_idle_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_idle_ack"},   {31'd0, resp_ack}, 32'd0);
    chk({tag, "_idle_rdata"}, resp_rdata, model_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          e;
    logic [31:0] rd, addr, wd;
    logic [3:0]  strb;
    bit          ren, wen;
    int          kind;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'h20,  32'h0BADC0DE, 4'hF, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 32'h13,  32'h0,        4'hF, 1'b1, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b1, 32'h0,   32'h55555555, 4'hF, 1'b1, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b1, 32'h400, 32'h99999999, 4'hF, 1'b1, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,   32'h0,        4'hF, 1'b0, 32'hCAFEF00D};
    vecs[8]  = '{1'b0, 1'b1, 32'h3FC, 32'h0F0F0F0F, 4'hF, 1'b0, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        4'hF, 1'b0, 32'h0F0F0F0F};
    vecs[10] = '{1'b1, 1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 1'b0, 32'h80000000, 32'h0,   4'hF, 1'b1, 32'hDEADBEEF};
    vecs[12] = '{1'b0, 1'b1, 32'h12,  32'h00000001, 4'hF, 1'b1, 32'hDEADBEEF};
    vecs[13] = '{1'b1, 1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 32'hDEADBEEF};

    rst_n = 1'b0;
    req_ren = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'hF;
    w0_ren = 1'b0; w0_wen = 1'b0; w0_addr = 32'h0; w0_wdata = 32'h0;
    model_rdata = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_ack",   {31'd0, resp_ack}, 32'd0);
    chk("rst_err",   {31'd0, resp_err}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_w0_busy", {31'd0, w0_busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      xact(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
           vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));

    // Request inputs changed during WAIT must be ignored.
    @(posedge clk); #1;
    req_ren = 1'b1; req_addr = 32'h10;
    @(posedge clk); #1;
    req_ren = 1'b0; req_wen = 1'b1; req_addr = 32'h13; req_wdata = 32'h0;
    @(negedge clk);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("hold_ack_early", {31'd0, resp_ack}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("hold_ack",   {31'd0, resp_ack}, 32'd1);
    chk("hold_err",   {31'd0, resp_err}, 32'd0);
    chk("hold_rdata", resp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    req_wen = 1'b0;
    xact(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, "hold_reread");

    // Reset in the ERR cycle deasserts ack/err without a clock edge.
    @(posedge clk); #1;
    req_ren = 1'b1; req_addr = 32'h15;
    @(posedge clk); #1;
    chk("rerr_ack_before", {31'd0, resp_ack}, 32'd1);
    chk("rerr_err_before", {31'd0, resp_err}, 32'd1);
    rst_n = 1'b0; #1;
    chk("rerr_ack", {31'd0, resp_ack}, 32'd0);
    chk("rerr_err", {31'd0, resp_err}, 32'd0);
    chk("rerr_busy", {31'd0, busy}, 32'd0);
    req_ren = 1'b0;
    @(negedge clk);
    chk("rerr_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_rdata = 32'h0;

    // Reset during WAIT drops the pending write.
    @(posedge clk); #1;
    req_wen = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    chk("rwait_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0; #1;
    chk("rwait_ack",  {31'd0, resp_ack}, 32'd0);
    chk("rwait_busy", {31'd0, busy}, 32'd0);
    req_wen = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    xact(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h0BADC0DE, "rwait_read");

`ifdef MEM_BYTE_EN_EN
    xact(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0BADC0DE, "be_init");
    xact(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0BADC0DE, "be_w0101");
    xact(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h11BB33DD, "be_read");
    xact(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h11BB33DD, "be_w0000");
    xact(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h11BB33DD, "be_reread");
`endif

    // Zero wait states: write, then continuously held reads.
    @(posedge clk); #1;
    w0_wen = 1'b1; w0_addr = 32'h8; w0_wdata = 32'h600DF00D;
    @(negedge clk);
    chk("w0_wr_stall", {31'd0, w0_stall}, 32'd1);
    chk("w0_wr_ack0",  {31'd0, w0_ack}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("w0_wr_ack",   {31'd0, w0_ack}, 32'd1);
    chk("w0_wr_err",   {31'd0, w0_err}, 32'd0);
    chk("w0_wr_stall1", {31'd0, w0_stall}, 32'd0);
    @(posedge clk); #1;
    w0_wen = 1'b0;
    @(negedge clk);
    chk("w0_idle_busy", {31'd0, w0_busy}, 32'd0);
    @(posedge clk); #1;
    w0_ren = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("w0_rd_stall%0d", i), {31'd0, w0_stall}, {31'd0, (i % 2) == 0});
      chk($sformatf("w0_rd_ack%0d", i),   {31'd0, w0_ack},   {31'd0, (i % 2) == 1});
      if (w0_ack) chk($sformatf("w0_rd_data%0d", i), w0_rdata, 32'h600DF00D);
      @(posedge clk);
    end
    #1 w0_ren = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 8; n++) begin
      addr = 32'h40 + 32'(4 * n);
      wd   = $urandom;
      model_apply(1'b0, 1'b1, addr, wd, 4'hF, e, rd);
      xact(1'b0, 1'b1, addr, wd, 4'hF, e, rd, "rnd_init");
    end
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      addr = 32'h40 + 32'(4 * $urandom_range(0, 7));
      wd   = $urandom;
      strb = 4'($urandom_range(0, 15));
      ren  = 1'b1;
      wen  = 1'b0;
      if (kind >= 4 && kind < 7) begin
        ren = 1'b0; wen = 1'b1;
      end else if (kind == 7) begin
        addr = addr | 32'($urandom_range(1, 3));
        ren = $urandom_range(0, 1) != 0; wen = !ren;
      end else if (kind == 8) begin
        addr = addr | (32'h1 << $urandom_range(10, 31));
        ren = $urandom_range(0, 1) != 0; wen = !ren;
      end else if (kind == 9) begin
        wen = 1'b1;
      end
      model_apply(ren, wen, addr, wd, strb, e, rd);
      xact(ren, wen, addr, wd, strb, e, rd, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
